// File: rtl/led_pwm_pkg.sv
// Shared constants and types for the LED PWM controller.
// Optional build macro: LED_PWM_FADE_EN (see led_pwm_chan).
package led_pwm_pkg;

    // Word offsets, decoded from byte address bits [9:2]
    localparam logic [7:0] CTRL_OFFSET      = 8'h00;
    localparam logic [7:0] PRESCALE_OFFSET  = 8'h01;
    localparam logic [7:0] DUTY_BASE_OFFSET = 8'h04;

    // CTRL bit positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_INV_BIT = 1;

    typedef struct packed {
        logic inv;
        logic en;
    } ctrl_reg_t;

    // Expand 4 byte enables to a 32-bit write mask
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// One PWM channel: duty shadow, active duty and registered compare output.
// With LED_PWM_FADE_EN defined, the active duty walks one step per period
// toward the shadow instead of jumping.
module led_pwm_chan
    import led_pwm_pkg::*;
#(
    parameter int CtrWidth = 8
) (
    input  logic                clk_sys_i,
    input  logic                rst_sys_i,
    input  logic                en,
    input  logic                inv,
    input  logic                wrap,
    input  logic                duty_we,
    input  logic [CtrWidth-1:0] duty_wdata,
    input  logic [CtrWidth-1:0] duty_wmask,
    input  logic [CtrWidth-1:0] pwm_cnt,
    output logic [CtrWidth-1:0] shadow,
    output logic                pwm
);

    logic [CtrWidth-1:0] duty_act;

    // Byte-masked software write into the shadow
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i)
            shadow <= '0;
        else if (duty_we)
            shadow <= (shadow & ~duty_wmask) | (duty_wdata & duty_wmask);
    end

    // Active duty follows shadow while disabled, otherwise only at period wrap
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i)
            duty_act <= '0;
        else if (!en)
            duty_act <= shadow;
`ifdef LED_PWM_FADE_EN
        else if (wrap) begin
            if (duty_act < shadow)
                duty_act <= duty_act + 1'b1;
            else if (duty_act > shadow)
                duty_act <= duty_act - 1'b1;
        end
`else
        else if (wrap)
            duty_act <= shadow;
`endif
    end

    // Registered compare; with en low this settles to the INV level
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i)
            pwm <= 1'b0;
        else
            pwm <= (en & (pwm_cnt < duty_act)) ^ inv;
    end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Bus-mapped PWM controller: register decode, shared prescaler and period
// counter, and an array of led_pwm_chan instances.
// Optional build macro: LED_PWM_FADE_EN (gradual duty fade per period).
module led_pwm_ctrl
    import led_pwm_pkg::*;
#(
    parameter int NumChannels   = 16,
    parameter int CtrWidth      = 8,
    parameter int PrescaleWidth = 16
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_sys_i,
    input  logic                   device_req_i,
    input  logic [31:0]            device_addr_i,
    input  logic                   device_we_i,
    input  logic [3:0]             device_be_i,
    input  logic [31:0]            device_wdata_i,
    output logic                   device_rvalid_o,
    output logic [31:0]            device_rdata_o,
    output logic [NumChannels-1:0] pwm_o,
    output logic                   period_start_o
);

    logic [7:0]  word;
    logic [31:0] wmask;
    logic        wr;
    logic        ctrl_hit;
    logic        pre_hit;

    assign word     = device_addr_i[9:2];
    assign wmask    = be_to_mask(device_be_i);
    assign wr       = device_req_i & device_we_i;
    assign ctrl_hit = (word == CTRL_OFFSET);
    assign pre_hit  = (word == PRESCALE_OFFSET);

    ctrl_reg_t                               ctrl;
    logic [PrescaleWidth-1:0]                prescale;
    logic [PrescaleWidth-1:0]                pre_cnt;
    logic [CtrWidth-1:0]                     pwm_cnt;
    logic                                    tick;
    logic                                    wrap;
    logic [NumChannels-1:0][CtrWidth-1:0]    duty_shadow;
    logic [NumChannels-1:0]                  duty_hit;
    logic [31:0]                             rd_mux;

    // Address bits outside [9:2] and high write-data bits are not decoded
    logic unused_bits;
    assign unused_bits = ^{device_addr_i[31:10], device_addr_i[1:0], device_wdata_i, wmask};

    // CTRL and PRESCALE registers
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            ctrl     <= '0;
            prescale <= '0;
        end else if (wr) begin
            if (ctrl_hit && device_be_i[0]) begin
                ctrl.en  <= device_wdata_i[CTRL_EN_BIT];
                ctrl.inv <= device_wdata_i[CTRL_INV_BIT];
            end
            if (pre_hit)
                prescale <= (prescale & ~wmask[PrescaleWidth-1:0]) |
                            (device_wdata_i[PrescaleWidth-1:0] & wmask[PrescaleWidth-1:0]);
        end
    end

    // A new PRESCALE below pre_cnt is only matched after pre_cnt wraps
    assign tick = ctrl.en && (pre_cnt == prescale);
    assign wrap = tick && (pwm_cnt == '1);

    // Prescaler and period counter, both parked at 0 while disabled
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            pre_cnt        <= '0;
            pwm_cnt        <= '0;
            period_start_o <= 1'b0;
        end else begin
            period_start_o <= wrap;
            if (!ctrl.en) begin
                pre_cnt <= '0;
                pwm_cnt <= '0;
            end else begin
                pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                if (tick)
                    pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    // Read data selection; unmapped offsets read as 0
    always_comb begin
        rd_mux = '0;
        if (ctrl_hit)
            rd_mux = {30'b0, ctrl.inv, ctrl.en};
        if (pre_hit)
            rd_mux = 32'(prescale);
        for (int i = 0; i < NumChannels; i++)
            if (duty_hit[i])
                rd_mux = 32'(duty_shadow[i]);
    end

    // Single-cycle response; rdata holds between requests, 0 for writes
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            device_rvalid_o <= 1'b0;
            device_rdata_o  <= '0;
        end else begin
            device_rvalid_o <= device_req_i;
            if (device_req_i)
                device_rdata_o <= device_we_i ? 32'b0 : rd_mux;
        end
    end

    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
        assign duty_hit[gi] = (word == DUTY_BASE_OFFSET + 8'(gi));

        led_pwm_chan #(.CtrWidth(CtrWidth)) u_chan (
            .clk_sys_i  (clk_sys_i),
            .rst_sys_i  (rst_sys_i),
            .en         (ctrl.en),
            .inv        (ctrl.inv),
            .wrap       (wrap),
            .duty_we    (wr & duty_hit[gi]),
            .duty_wdata (device_wdata_i[CtrWidth-1:0]),
            .duty_wmask (wmask[CtrWidth-1:0]),
            .pwm_cnt    (pwm_cnt),
            .shadow     (duty_shadow[gi]),
            .pwm        (pwm_o[gi])
        );
    end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl: register table plus PWM timing sequences.
// Fade expectations switch on LED_PWM_FADE_EN.
module tb_led_pwm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic [15:0] pwm;
    logic        pstart;

    led_pwm_ctrl dut (
        .clk_sys_i       (clk),
        .rst_sys_i       (rst),
        .device_req_i    (req),
        .device_addr_i   (addr),
        .device_we_i     (we),
        .device_be_i     (be),
        .device_wdata_i  (wdata),
        .device_rvalid_o (rvalid),
        .device_rdata_o  (rdata),
        .pwm_o           (pwm),
        .period_start_o  (pstart)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus transaction; response sampled on the following negedge
    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rd);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        chk("rvalid", 32'(rvalid), 32'd1);
        rd = rdata;
    endtask

    // Per-period high count and length on one monitored channel
    int mon_ch = 0;
    int hi_acc = 0, len_acc = 0, period_hi = 0, period_len = 0, nperiods = 0;

    always @(negedge clk) begin
        if (pstart) begin
            period_hi  = hi_acc;
            period_len = len_acc;
            hi_acc     = int'(pwm[mon_ch]);
            len_acc    = 1;
            nperiods++;
        end else begin
            hi_acc  += int'(pwm[mon_ch]);
            len_acc += 1;
        end
    end

    task automatic wait_period();
        int n;
        int k;
        n = nperiods;
        k = 0;
        while (nperiods == n && k < 3000) begin
            @(posedge clk);
            k++;
        end
        if (nperiods == n) begin
            checks++;
            errors++;
            $display("FAIL period_timeout: got no period_start expected one within 3000 cycles");
        end
    endtask

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [0:24];
    logic [31:0] rd;
    int          cnt_a, cnt_b;
    int          fexp [0:4];

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;

        tbl[0]  = '{1'b0, 32'h000, 4'hF, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 32'h004, 4'hF, 32'h0,        32'h0};
        tbl[2]  = '{1'b0, 32'h010, 4'hF, 32'h0,        32'h0};
        tbl[3]  = '{1'b1, 32'h004, 4'hF, 32'h12345678, 32'h0};
        tbl[4]  = '{1'b0, 32'h004, 4'hF, 32'h0,        32'h5678};
        tbl[5]  = '{1'b1, 32'h004, 4'h2, 32'hFFFFAB11, 32'h0};
        tbl[6]  = '{1'b0, 32'h004, 4'hF, 32'h0,        32'hAB78};
        tbl[7]  = '{1'b1, 32'h014, 4'hF, 32'h1FF,      32'h0};
        tbl[8]  = '{1'b0, 32'h014, 4'hF, 32'h0,        32'hFF};
        tbl[9]  = '{1'b1, 32'h014, 4'h0, 32'h11,       32'h0};
        tbl[10] = '{1'b0, 32'h014, 4'hF, 32'h0,        32'hFF};
        tbl[11] = '{1'b1, 32'h3FC, 4'hF, 32'hFFFFFFFF, 32'h0};
        tbl[12] = '{1'b0, 32'h3FC, 4'hF, 32'h0,        32'h0};
        tbl[13] = '{1'b1, 32'h008, 4'hF, 32'h55,       32'h0};
        tbl[14] = '{1'b0, 32'h008, 4'hF, 32'h0,        32'h0};
        tbl[15] = '{1'b1, 32'h04C, 4'hF, 32'h5A,       32'h0};
        tbl[16] = '{1'b0, 32'h04C, 4'hF, 32'h0,        32'h5A};
        tbl[17] = '{1'b0, 32'h050, 4'hF, 32'h0,        32'h0};
        tbl[18] = '{1'b1, 32'h000, 4'hE, 32'h3,        32'h0};
        tbl[19] = '{1'b0, 32'h000, 4'hF, 32'h0,        32'h0};
        tbl[20] = '{1'b1, 32'h000, 4'hF, 32'hFFFFFFFC, 32'h0};
        tbl[21] = '{1'b0, 32'h000, 4'hF, 32'h0,        32'h0};
        tbl[22] = '{1'b1, 32'h004, 4'hF, 32'h0,        32'h0};
        tbl[23] = '{1'b1, 32'h014, 4'hF, 32'h0,        32'h0};
        tbl[24] = '{1'b1, 32'h04C, 4'hF, 32'h0,        32'h0};

        repeat (3) @(negedge clk);
        chk("reset_pwm", 32'(pwm), 32'h0);
        chk("reset_pstart", 32'(pstart), 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        rst = 1'b0;

        // Register table: response next cycle, rvalid single-cycle, rdata holds
        for (int i = 0; i < 25; i++) begin
            bus(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, rd);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
            @(negedge clk);
            chk($sformatf("tbl%0d_rvalid_drop", i), 32'(rvalid), 32'h0);
            chk($sformatf("tbl%0d_rdata_hold", i), rdata, tbl[i].exp);
        end
        chk("disabled_pwm", 32'(pwm), 32'h0);
        chk("disabled_pstart", 32'(pstart), 32'h0);

        // DUTY[0]=64, prescale 0: 64 high per 256-cycle period
        bus(1'b1, 32'h010, 4'hF, 32'd64, rd);
        bus(1'b1, 32'h000, 4'hF, 32'h1, rd);
        wait_period();
        wait_period();
        chk("duty64_hi", 32'(period_hi), 32'd64);
        chk("duty64_len", 32'(period_len), 32'd256);

        // Mid-period change to 200: current period keeps 64
        wait_period();
        repeat (100) @(posedge clk);
        bus(1'b1, 32'h010, 4'hF, 32'd200, rd);
        wait_period();
        chk("midwrite_old_hi", 32'(period_hi), 32'd64);
        wait_period();
        chk("midwrite_new_hi", 32'(period_hi), 32'd200);
        chk("midwrite_len", 32'(period_len), 32'd256);

        // Write landing exactly on the wrap tick: old shadow (200) wins once
        repeat (254) @(posedge clk);
        bus(1'b1, 32'h010, 4'hF, 32'd100, rd);
        @(posedge clk);
        wait_period();
        chk("wrapwrite_old_hi", 32'(period_hi), 32'd200);
        wait_period();
        chk("wrapwrite_new_hi", 32'(period_hi), 32'd100);
        bus(1'b1, 32'h010, 4'hF, 32'd200, rd);

        // EN+INV: DUTY[1]=0 gives constant 1, DUTY[0]=200 gives 56 high
        bus(1'b1, 32'h000, 4'hF, 32'h3, rd);
        @(negedge clk);
        cnt_a = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pwm[1] !== 1'b1) cnt_a++;
        end
        chk("inv_duty0_lows", 32'(cnt_a), 32'd0);
        wait_period();
        wait_period();
        chk("inv_duty200_hi", 32'(period_hi), 32'd56);

        // EN=0, INV=1: all outputs high, no period pulses
        bus(1'b1, 32'h000, 4'hF, 32'h2, rd);
        @(negedge clk);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (pwm !== 16'hFFFF) cnt_a++;
            if (pstart !== 1'b0) cnt_b++;
        end
        chk("off_inv_pwm_bad", 32'(cnt_a), 32'd0);
        chk("off_pstart_pulses", 32'(cnt_b), 32'd0);

        // PRESCALE=3: 1024-cycle period, 4 cycles per count
        bus(1'b1, 32'h004, 4'hF, 32'd3, rd);
        bus(1'b1, 32'h000, 4'hF, 32'h1, rd);
        bus(1'b1, 32'h3FC, 4'hF, 32'hFFFFFFFF, rd);
        bus(1'b0, 32'h3FC, 4'hF, 32'h0, rd);
        chk("unmapped_read_running", rd, 32'h0);
        wait_period();
        wait_period();
        chk("pre3_len", 32'(period_len), 32'd1024);
        chk("pre3_hi", 32'(period_hi), 32'd800);

        // Asynchronous reset with a response in flight
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'hF;
        @(posedge clk);
        #2;
        chk("pre_reset_rvalid", 32'(rvalid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_rvalid", 32'(rvalid), 32'd0);
        chk("async_rst_pwm", 32'(pwm), 32'd0);
        chk("async_rst_pstart", 32'(pstart), 32'd0);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus(1'b0, 32'h010, 4'hF, 32'h0, rd);
        chk("post_rst_duty0", rd, 32'h0);
        bus(1'b0, 32'h004, 4'hF, 32'h0, rd);
        chk("post_rst_prescale", rd, 32'h0);

        // DUTY[2]: 10 -> 14 (step-wise with fade, one jump otherwise)
`ifdef LED_PWM_FADE_EN
        fexp[0] = 11; fexp[1] = 12; fexp[2] = 13; fexp[3] = 14; fexp[4] = 14;
`else
        fexp[0] = 14; fexp[1] = 14; fexp[2] = 14; fexp[3] = 14; fexp[4] = 14;
`endif
        mon_ch = 2;
        bus(1'b1, 32'h018, 4'hF, 32'd10, rd);
        bus(1'b1, 32'h000, 4'hF, 32'h1, rd);
        wait_period();
        wait_period();
        chk("fade_start_hi", 32'(period_hi), 32'd10);
        bus(1'b1, 32'h018, 4'hF, 32'd14, rd);
        wait_period();
        chk("fade_p0_hi", 32'(period_hi), 32'd10);
        for (int i = 0; i < 5; i++) begin
            wait_period();
            chk($sformatf("fade_p%0d_hi", i + 1), 32'(period_hi), 32'(fexp[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
